// File: rtl/axi2ddr_prot_pkg.sv
// Shared types and constants for the AXI-to-DDR write-channel guard.
// Holds the FSM states, the legal burst lengths and the BRESP codes.
package axi2ddr_prot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PASS_AW,
        ST_PASS_W,
        ST_PASS_B,
        ST_DROP_W,
        ST_DROP_B
    } wr_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [7:0] LEN_4   = 8'd3;
    localparam logic [7:0] LEN_8   = 8'd7;
    localparam logic [7:0] LEN_16  = 8'd15;
    localparam logic [7:0] LEN_32  = 8'd31;
    localparam logic [7:0] LEN_64  = 8'd63;
    localparam logic [7:0] LEN_128 = 8'd127;
    localparam logic [7:0] LEN_256 = 8'd255;

    // Every AW field except the address, which is sized by a module parameter.
    typedef struct packed {
        logic [1:0] burst;
        logic [3:0] cache;
        logic [3:0] id;
        logic [7:0] len;
        logic       lock;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [2:0] size;
        logic       user;
    } aw_ctrl_t;

    function automatic logic is_legal_len(input logic [7:0] len);
        case (len)
            LEN_4, LEN_8, LEN_16, LEN_32, LEN_64, LEN_128, LEN_256: return 1'b1;
            default:                                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cmip_app_cnt.sv
// Event counter with synchronous clear; wraps modulo 2^CNT_WD.
module cmip_app_cnt #(
    parameter int unsigned CNT_WD = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_vld,
    output logic [CNT_WD-1:0] o_cnt
);

    logic [CNT_WD-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (i_clr) begin
            cnt_q <= '0;
        end else if (i_vld) begin
            cnt_q <= cnt_q + CNT_WD'(1);
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/axi2ddr_wr_protect.sv
// AXI4 write guard in front of the DDR controller: forwards legal bursts,
// sinks illegal-length bursts locally with an error BRESP and counts them.
module axi2ddr_wr_protect
    import axi2ddr_prot_pkg::*;
#(
    parameter int unsigned AXI_DATA_WD = 128,
    parameter int unsigned AXI_ADDR_WD = 64,
    parameter bit          DGBCNT_EN   = 1'b1,
    parameter int unsigned DGBCNT_WD   = 32,
    parameter logic [1:0]  ERR_RESP    = 2'b10
) (
    input  logic                     axi_clk,
    input  logic                     axi_rst_n,
    input  logic                     cfg_rst,

    input  logic [AXI_ADDR_WD-1:0]   s_axi_awaddr,
    input  logic [1:0]               s_axi_awburst,
    input  logic [3:0]               s_axi_awcache,
    input  logic [3:0]               s_axi_awid,
    input  logic [7:0]               s_axi_awlen,
    input  logic                     s_axi_awlock,
    input  logic [2:0]               s_axi_awprot,
    input  logic [3:0]               s_axi_awqos,
    input  logic [2:0]               s_axi_awsize,
    input  logic                     s_axi_awuser,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [AXI_DATA_WD-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WD/8-1:0] s_axi_wstrb,
    input  logic                     s_axi_wlast,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    output logic [1:0]               s_axi_bresp,
    output logic [3:0]               s_axi_bid,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,

    output logic [AXI_ADDR_WD-1:0]   m_axi_awaddr,
    output logic [1:0]               m_axi_awburst,
    output logic [3:0]               m_axi_awcache,
    output logic [3:0]               m_axi_awid,
    output logic [7:0]               m_axi_awlen,
    output logic                     m_axi_awlock,
    output logic [2:0]               m_axi_awprot,
    output logic [3:0]               m_axi_awqos,
    output logic [2:0]               m_axi_awsize,
    output logic                     m_axi_awuser,
    output logic                     m_axi_awvalid,
    input  logic                     m_axi_awready,
    output logic [AXI_DATA_WD-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WD/8-1:0] m_axi_wstrb,
    output logic                     m_axi_wlast,
    output logic                     m_axi_wvalid,
    input  logic                     m_axi_wready,
    input  logic [1:0]               m_axi_bresp,
    input  logic [3:0]               m_axi_bid,
    input  logic                     m_axi_bvalid,
    output logic                     m_axi_bready,

    output logic [DGBCNT_WD-1:0]     err_wr_cnt
);

    wr_state_e              state_q, state_d;
    logic [AXI_ADDR_WD-1:0] awaddr_q;
    aw_ctrl_t               awctl_q;
    logic [7:0]             beat_q, beat_d;
    logic                   aw_hs;
    logic                   drop_vld;

    // awready is held low during reset and during a soft clear so no AW slips past either.
    assign s_axi_awready = (state_q == ST_IDLE) & axi_rst_n & ~cfg_rst;
    assign aw_hs         = s_axi_awvalid & s_axi_awready;
    assign drop_vld      = aw_hs & ~is_legal_len(s_axi_awlen);

    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            awaddr_q <= '0;
            awctl_q  <= '0;
        end else if (cfg_rst) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            awaddr_q <= '0;
            awctl_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (aw_hs) begin
                awaddr_q <= s_axi_awaddr;
                awctl_q  <= '{burst: s_axi_awburst, cache: s_axi_awcache, id: s_axi_awid,
                              len: s_axi_awlen, lock: s_axi_awlock, prot: s_axi_awprot,
                              qos: s_axi_awqos, size: s_axi_awsize, user: s_axi_awuser};
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        m_axi_awaddr  = '0;
        m_axi_awburst = '0;
        m_axi_awcache = '0;
        m_axi_awid    = '0;
        m_axi_awlen   = '0;
        m_axi_awlock  = 1'b0;
        m_axi_awprot  = '0;
        m_axi_awqos   = '0;
        m_axi_awsize  = '0;
        m_axi_awuser  = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wdata   = '0;
        m_axi_wstrb   = '0;
        m_axi_wlast   = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bresp   = '0;
        s_axi_bid     = '0;
        s_axi_bvalid  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (aw_hs) begin
                    beat_d  = '0;
                    state_d = is_legal_len(s_axi_awlen) ? ST_PASS_AW : ST_DROP_W;
                end
            end
            ST_PASS_AW: begin
                m_axi_awvalid = 1'b1;
                m_axi_awaddr  = awaddr_q;
                m_axi_awburst = awctl_q.burst;
                m_axi_awcache = awctl_q.cache;
                m_axi_awid    = awctl_q.id;
                m_axi_awlen   = awctl_q.len;
                m_axi_awlock  = awctl_q.lock;
                m_axi_awprot  = awctl_q.prot;
                m_axi_awqos   = awctl_q.qos;
                m_axi_awsize  = awctl_q.size;
                m_axi_awuser  = awctl_q.user;
                if (m_axi_awready) state_d = ST_PASS_W;
            end
            ST_PASS_W: begin
                m_axi_wvalid = s_axi_wvalid;
                m_axi_wdata  = s_axi_wdata;
                m_axi_wstrb  = s_axi_wstrb;
                m_axi_wlast  = s_axi_wlast;
                s_axi_wready = m_axi_wready;
                if (s_axi_wvalid && m_axi_wready && s_axi_wlast) state_d = ST_PASS_B;
            end
            ST_PASS_B: begin
                s_axi_bvalid = m_axi_bvalid;
                s_axi_bresp  = m_axi_bresp;
                s_axi_bid    = m_axi_bid;
                m_axi_bready = s_axi_bready;
                if (m_axi_bvalid && s_axi_bready) state_d = ST_IDLE;
            end
            ST_DROP_W: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid) begin
                    beat_d = beat_q + 8'd1;
                    // A master that never raises wlast is cut off after AWLEN+1 beats.
                    if (s_axi_wlast || beat_q == awctl_q.len) state_d = ST_DROP_B;
                end
            end
            ST_DROP_B: begin
                s_axi_bvalid = 1'b1;
                s_axi_bresp  = ERR_RESP;
                s_axi_bid    = awctl_q.id;
                if (s_axi_bready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    if (DGBCNT_EN) begin : g_err_cnt
        cmip_app_cnt #(
            .CNT_WD(DGBCNT_WD)
        ) u_err_cnt (
            .clk  (axi_clk),
            .rst_n(axi_rst_n),
            .i_clr(cfg_rst),
            .i_vld(drop_vld),
            .o_cnt(err_wr_cnt)
        );
    end else begin : g_no_err_cnt
        assign err_wr_cnt = '0;
    end

endmodule

// File: tb/tb_axi2ddr_wr_protect.sv
// Directed plus randomized bench for axi2ddr_wr_protect with a transaction-level model.
module tb_axi2ddr_wr_protect;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_rst;
    logic [63:0]  s_axi_awaddr;
    logic [1:0]   s_axi_awburst;
    logic [3:0]   s_axi_awcache;
    logic [3:0]   s_axi_awid;
    logic [7:0]   s_axi_awlen;
    logic         s_axi_awlock;
    logic [2:0]   s_axi_awprot;
    logic [3:0]   s_axi_awqos;
    logic [2:0]   s_axi_awsize;
    logic         s_axi_awuser;
    logic         s_axi_awvalid;
    logic         s_axi_awready;
    logic [127:0] s_axi_wdata;
    logic [15:0]  s_axi_wstrb;
    logic         s_axi_wlast;
    logic         s_axi_wvalid;
    logic         s_axi_wready;
    logic [1:0]   s_axi_bresp;
    logic [3:0]   s_axi_bid;
    logic         s_axi_bvalid;
    logic         s_axi_bready;
    logic [63:0]  m_axi_awaddr;
    logic [1:0]   m_axi_awburst;
    logic [3:0]   m_axi_awcache;
    logic [3:0]   m_axi_awid;
    logic [7:0]   m_axi_awlen;
    logic         m_axi_awlock;
    logic [2:0]   m_axi_awprot;
    logic [3:0]   m_axi_awqos;
    logic [2:0]   m_axi_awsize;
    logic         m_axi_awuser;
    logic         m_axi_awvalid;
    logic         m_axi_awready;
    logic [127:0] m_axi_wdata;
    logic [15:0]  m_axi_wstrb;
    logic         m_axi_wlast;
    logic         m_axi_wvalid;
    logic         m_axi_wready;
    logic [1:0]   m_axi_bresp;
    logic [3:0]   m_axi_bid;
    logic         m_axi_bvalid;
    logic         m_axi_bready;
    logic [31:0]  err_wr_cnt;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    axi2ddr_wr_protect #(
        .AXI_DATA_WD(128),
        .AXI_ADDR_WD(64),
        .DGBCNT_EN  (1'b1),
        .DGBCNT_WD  (32),
        .ERR_RESP   (2'b10)
    ) dut (
        .axi_clk(clk), .axi_rst_n(rst_n), .cfg_rst(cfg_rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awburst(s_axi_awburst), .s_axi_awcache(s_axi_awcache),
        .s_axi_awid(s_axi_awid), .s_axi_awlen(s_axi_awlen), .s_axi_awlock(s_axi_awlock),
        .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos), .s_axi_awsize(s_axi_awsize),
        .s_axi_awuser(s_axi_awuser), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bid(s_axi_bid), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache),
        .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen), .m_axi_awlock(m_axi_awlock),
        .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos), .m_axi_awsize(m_axi_awsize),
        .m_axi_awuser(m_axi_awuser), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bid(m_axi_bid), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .err_wr_cnt(err_wr_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A burst length is legal when it is a power of two of at least 4 beats.
    function automatic bit legal_len(input int len);
        return (len >= 3) && (((len + 1) & len) == 0);
    endfunction

    task automatic clear_inputs();
        s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awid = '0;
        s_axi_awburst = '0; s_axi_awcache = '0; s_axi_awlock = 1'b0; s_axi_awprot = '0;
        s_axi_awqos = '0; s_axi_awsize = '0; s_axi_awuser = 1'b0;
        s_axi_wvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
        s_axi_bready = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_bresp = '0; m_axi_bid = '0;
    endtask

    // One complete transaction; wlast_at is the 1-based beat carrying wlast (0 = never).
    task automatic do_burst(input logic [7:0] len, input logic [3:0] id, input logic [63:0] addr,
                            input int wlast_at, input bit gaps, input logic [1:0] ddr_resp);
        bit          legal;
        int          nbeats, beat, cyc, stall;
        logic        done;
        logic [17:0] ctl;
        legal = legal_len(int'(len));
        if (legal) begin
            nbeats   = int'(len) + 1;
            wlast_at = nbeats;
        end else begin
            nbeats = (wlast_at >= 1 && wlast_at <= int'(len) + 1) ? wlast_at : int'(len) + 1;
        end

        @(posedge clk); #1;
        s_axi_awvalid = 1'b1; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awid = id;
        ctl = 18'($urandom);
        {s_axi_awburst, s_axi_awcache, s_axi_awlock, s_axi_awprot,
         s_axi_awqos, s_axi_awsize, s_axi_awuser} = ctl;
        @(negedge clk);
        chk("aw_ready_idle", s_axi_awready, 1'b1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_awaddr = {$urandom, $urandom}; s_axi_awlen = 8'($urandom);
        s_axi_awid = 4'($urandom);
        @(negedge clk);
        chk("aw_ready_busy", s_axi_awready, 1'b0);
        if (legal) begin
            chk("m_awvalid", m_axi_awvalid, 1'b1);
            chk("m_awaddr", m_axi_awaddr, addr);
            chk("m_awlen", m_axi_awlen, len);
            chk("m_awid", m_axi_awid, id);
            chk("m_awctl", {m_axi_awburst, m_axi_awcache, m_axi_awlock, m_axi_awprot,
                            m_axi_awqos, m_axi_awsize, m_axi_awuser}, ctl);
            stall = gaps ? $urandom_range(0, 3) : 0;
            for (int i = 0; i <= stall; i++) begin
                @(posedge clk); #1;
                m_axi_awready = (i == stall); s_axi_wvalid = 1'b1; m_axi_wready = 1'b1;
                @(negedge clk);
                chk("m_awvalid_hold", m_axi_awvalid, 1'b1);
                chk("m_awaddr_hold", m_axi_awaddr, addr);
                chk("w_stall_pre_aw", s_axi_wready, 1'b0);
                chk("m_wvalid_pre_aw", m_axi_wvalid, 1'b0);
            end
        end else begin
            chk("m_awvalid_drop", m_axi_awvalid, 1'b0);
            exp_cnt++;
            chk("err_cnt_inc", err_wr_cnt, exp_cnt);
        end

        beat = 0; cyc = 0;
        while (beat < nbeats && cyc < 2000) begin
            @(posedge clk); #1;
            m_axi_awready = 1'b0;
            s_axi_wvalid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_axi_wdata   = {$urandom, $urandom, $urandom, $urandom};
            s_axi_wstrb   = 16'($urandom);
            s_axi_wlast   = (beat + 1 == wlast_at);
            m_axi_wready  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            chk("m_awvalid_in_w", m_axi_awvalid, 1'b0);
            if (legal) begin
                chk("w_ready_pass", s_axi_wready, m_axi_wready);
                chk("m_wvalid_pass", m_axi_wvalid, s_axi_wvalid);
                if (s_axi_wvalid) begin
                    chk("m_wdata", m_axi_wdata, s_axi_wdata);
                    chk("m_wstrb", m_axi_wstrb, s_axi_wstrb);
                    chk("m_wlast", m_axi_wlast, s_axi_wlast);
                end
                if (s_axi_wvalid && m_axi_wready) beat++;
            end else begin
                chk("w_ready_drop", s_axi_wready, 1'b1);
                chk("m_wvalid_drop", m_axi_wvalid, 1'b0);
                chk("m_wdata_drop", m_axi_wdata, '0);
                if (s_axi_wvalid) beat++;
            end
            cyc++;
        end
        chk("w_beats", beat, nbeats);

        @(posedge clk); #1;
        s_axi_wvalid = 1'b1; s_axi_wlast = 1'b0; m_axi_wready = 1'b1;
        done = 1'b0; cyc = 0;
        stall = (legal && gaps) ? $urandom_range(0, 3) : 0;
        while (!done && cyc < 100) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            s_axi_bready = gaps ? ($urandom_range(0, 1) != 0) : 1'b1;
            if (legal) begin
                m_axi_bvalid = (cyc >= stall); m_axi_bresp = ddr_resp; m_axi_bid = id;
            end
            @(negedge clk);
            chk("w_ready_in_b", s_axi_wready, 1'b0);
            chk("aw_ready_in_b", s_axi_awready, 1'b0);
            if (legal) begin
                chk("s_bvalid_pass", s_axi_bvalid, m_axi_bvalid);
                chk("m_bready_pass", m_axi_bready, s_axi_bready);
                if (m_axi_bvalid) begin
                    chk("s_bresp_pass", s_axi_bresp, ddr_resp);
                    chk("s_bid_pass", s_axi_bid, id);
                end
                done = m_axi_bvalid && s_axi_bready;
            end else begin
                chk("s_bvalid_drop", s_axi_bvalid, 1'b1);
                chk("s_bresp_drop", s_axi_bresp, 2'b10);
                chk("s_bid_drop", s_axi_bid, id);
                chk("m_bready_drop", m_axi_bready, 1'b0);
                done = s_axi_bready;
            end
            cyc++;
        end
        chk("b_done", done, 1'b1);
        @(posedge clk); #1;
        s_axi_bready = 1'b0; m_axi_bvalid = 1'b0; s_axi_wvalid = 1'b0;
        @(negedge clk);
        chk("aw_ready_after_b", s_axi_awready, 1'b1);
        chk("s_bvalid_after_b", s_axi_bvalid, 1'b0);
        chk("err_cnt", err_wr_cnt, exp_cnt);
    endtask

    initial begin
        logic [7:0] rlen;
        int         k;
        rst_n = 1'b0; cfg_rst = 1'b0;
        clear_inputs();
        #12;
        chk("rst_awready", s_axi_awready, 1'b0);
        chk("rst_m_awvalid", m_axi_awvalid, 1'b0);
        chk("rst_m_wvalid", m_axi_wvalid, 1'b0);
        chk("rst_s_bvalid", s_axi_bvalid, 1'b0);
        chk("rst_err_cnt", err_wr_cnt, '0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_awready", s_axi_awready, 1'b1);

        do_burst(8'd7, 4'd1, 64'h1000, 0, 1'b0, 2'b00);
        do_burst(8'd5, 4'd3, 64'h2000, 0, 1'b0, 2'b00);
        do_burst(8'd9, 4'd4, 64'h3000, 4, 1'b0, 2'b00);
        do_burst(8'd9, 4'd5, 64'h3100, 0, 1'b0, 2'b00);
        do_burst(8'd255, 4'd6, 64'h4000, 0, 1'b1, 2'b00);
        do_burst(8'd0, 4'd7, 64'h5000, 0, 1'b1, 2'b00);
        do_burst(8'd3, 4'd8, 64'h6000, 0, 1'b1, 2'b01);

        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 1) != 0) begin
                k = $urandom_range(0, 4);
                rlen = 8'((4 << k) - 1);
            end else begin
                rlen = 8'($urandom_range(0, 40));
            end
            do_burst(rlen, 4'($urandom), {$urandom, $urandom}, $urandom_range(0, int'(rlen) + 3),
                     1'b1, 2'($urandom));
        end

        // Soft clear while an illegal burst is being sunk.
        @(posedge clk); #1;
        s_axi_awvalid = 1'b1; s_axi_awlen = 8'd20; s_axi_awid = 4'd5;
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b1;
        @(negedge clk);
        chk("cfg_pre_wready", s_axi_wready, 1'b1);
        chk("cfg_pre_cnt", err_wr_cnt, exp_cnt + 1);
        @(posedge clk); #1;
        cfg_rst = 1'b1;
        @(posedge clk); #1;
        cfg_rst = 1'b0; s_axi_wvalid = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        chk("cfg_awready", s_axi_awready, 1'b1);
        chk("cfg_wready", s_axi_wready, 1'b0);
        chk("cfg_s_bvalid", s_axi_bvalid, 1'b0);
        chk("cfg_m_awvalid", m_axi_awvalid, 1'b0);
        chk("cfg_m_wvalid", m_axi_wvalid, 1'b0);
        chk("cfg_err_cnt", err_wr_cnt, '0);
        do_burst(8'd15, 4'd9, 64'h7000, 0, 1'b1, 2'b00);

        // Hard reset in the middle of a forwarded data phase.
        do_burst(8'd1, 4'd2, 64'h7800, 0, 1'b0, 2'b00);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b1; s_axi_awlen = 8'd15; s_axi_awid = 4'd10; s_axi_awaddr = 64'h8000;
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; m_axi_awready = 1'b1;
        @(negedge clk);
        chk("hr_m_awvalid", m_axi_awvalid, 1'b1);
        @(posedge clk); #1;
        m_axi_awready = 1'b0; s_axi_wvalid = 1'b1; m_axi_wready = 1'b1;
        @(negedge clk);
        chk("hr_m_wvalid_pre", m_axi_wvalid, 1'b1);
        chk("hr_cnt_pre", err_wr_cnt, exp_cnt);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("hr_m_wvalid", m_axi_wvalid, 1'b0);
        chk("hr_wready", s_axi_wready, 1'b0);
        chk("hr_awready", s_axi_awready, 1'b0);
        chk("hr_m_awvalid_rst", m_axi_awvalid, 1'b0);
        chk("hr_err_cnt", err_wr_cnt, '0);
        clear_inputs();
        exp_cnt = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("hr_post_awready", s_axi_awready, 1'b1);
        do_burst(8'd7, 4'd11, 64'h9000, 0, 1'b1, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
